// File: rtl/iob_cache_be_axi_wb.sv
// iob_cache_be_axi_wb: AXI4 write-back cache back-end doing full-line burst refills and evictions
module iob_cache_be_axi_wb #(
    parameter int FE_ADDR_W = 32,
    parameter int FE_DATA_W = 32,
    parameter int BE_ADDR_W = FE_ADDR_W,
    parameter int BE_DATA_W = 32,
    parameter int WORD_OFF_W = 3,
    parameter int AXI_ID_W = 1,
    parameter int AXI_ID = 0,
    localparam int BE_BYTE_W = $clog2(BE_DATA_W / 8),
    localparam int LINE2BE_W = WORD_OFF_W - $clog2(BE_DATA_W / FE_DATA_W),
    localparam int BEATS = 2 ** LINE2BE_W,
    localparam int LINE_W = FE_DATA_W * (2 ** WORD_OFF_W),
    localparam int LA_W = FE_ADDR_W - BE_BYTE_W - LINE2BE_W
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   wb_valid,
    input  logic [LA_W-1:0]        wb_addr,
    input  logic [LINE_W-1:0]      wb_line,
    output logic                   wb_ready,
    input  logic                   replace_valid,
    input  logic [LA_W-1:0]        replace_addr,
    output logic                   replace,
    output logic                   read_valid,
    output logic [LINE2BE_W-1:0]   read_addr,
    output logic [BE_DATA_W-1:0]   read_rdata,
    output logic                   resp_err,
    output logic                   axi_arvalid,
    output logic [BE_ADDR_W-1:0]   axi_araddr,
    output logic [7:0]             axi_arlen,
    output logic [2:0]             axi_arsize,
    output logic [1:0]             axi_arburst,
    output logic [AXI_ID_W-1:0]    axi_arid,
    output logic                   axi_arlock,
    output logic [3:0]             axi_arcache,
    output logic [2:0]             axi_arprot,
    output logic [3:0]             axi_arqos,
    input  logic                   axi_arready,
    input  logic                   axi_rvalid,
    input  logic [BE_DATA_W-1:0]   axi_rdata,
    input  logic [1:0]             axi_rresp,
    input  logic                   axi_rlast,
    output logic                   axi_rready,
    output logic                   axi_awvalid,
    output logic [BE_ADDR_W-1:0]   axi_awaddr,
    output logic [7:0]             axi_awlen,
    output logic [2:0]             axi_awsize,
    output logic [1:0]             axi_awburst,
    output logic [AXI_ID_W-1:0]    axi_awid,
    output logic                   axi_awlock,
    output logic [3:0]             axi_awcache,
    output logic [2:0]             axi_awprot,
    output logic [3:0]             axi_awqos,
    input  logic                   axi_awready,
    output logic                   axi_wvalid,
    output logic [BE_DATA_W-1:0]   axi_wdata,
    output logic [BE_DATA_W/8-1:0] axi_wstrb,
    output logic                   axi_wlast,
    input  logic                   axi_wready,
    input  logic                   axi_bvalid,
    input  logic [1:0]             axi_bresp,
    output logic                   axi_bready
);
    localparam logic [2:0] IDLE = 3'd0, AW = 3'd1, W = 3'd2, B = 3'd3, AR = 3'd4, R = 3'd5;
    localparam logic [LINE2BE_W:0] LAST = (LINE2BE_W + 1)'(BEATS - 1);
    logic [2:0] state;
    logic [LINE2BE_W:0] cnt;
    logic [LA_W-1:0] addr_q;
    logic [LINE_W-1:0] line_q;
    logic last;
    logic [BE_ADDR_W-1:0] line_addr;
    assign last = cnt == LAST;
    assign line_addr = BE_ADDR_W'({addr_q, {(BE_BYTE_W + LINE2BE_W){1'b0}}});
    assign axi_arvalid = state == AR;
    assign axi_araddr = line_addr;
    assign axi_arlen = 8'(BEATS - 1);
    assign axi_arsize = 3'(BE_BYTE_W);
    assign axi_arburst = 2'b01;
    assign axi_arid = AXI_ID_W'(AXI_ID);
    assign axi_arlock = 1'b0;
    assign axi_arcache = 4'b0011;
    assign axi_arprot = 3'd0;
    assign axi_arqos = 4'd0;
    assign axi_rready = state == R;
    assign axi_awvalid = state == AW;
    assign axi_awaddr = line_addr;
    assign axi_awlen = 8'(BEATS - 1);
    assign axi_awsize = 3'(BE_BYTE_W);
    assign axi_awburst = 2'b01;
    assign axi_awid = AXI_ID_W'(AXI_ID);
    assign axi_awlock = 1'b0;
    assign axi_awcache = 4'b0011;
    assign axi_awprot = 3'd0;
    assign axi_awqos = 4'd0;
    assign axi_wvalid = state == W;
    assign axi_wdata = line_q[BE_DATA_W*int'(cnt[LINE2BE_W-1:0]) +: BE_DATA_W];
    assign axi_wstrb = '1;
    assign axi_wlast = last;
    assign axi_bready = state == B;
    assign wb_ready = state == B && axi_bvalid;
    assign replace = state == AR || state == R;
    assign read_valid = state == R && axi_rvalid;
    assign read_addr = cnt[LINE2BE_W-1:0];
    assign read_rdata = axi_rdata;
    // the line address register serves both directions since only one burst is ever in flight
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            cnt <= '0;
            resp_err <= 1'b0;
        end else begin
            case (state)
                IDLE: if (wb_valid) begin
                    state <= AW;
                    addr_q <= wb_addr;
                    line_q <= wb_line;
                end else if (replace_valid) begin
                    state <= AR;
                    addr_q <= replace_addr;
                end
                AW: if (axi_awready) begin
                    state <= W;
                    cnt <= '0;
                end
                W: if (axi_wready) begin
                    cnt <= cnt + 1'b1;
                    if (last) state <= B;
                end
                B: if (axi_bvalid) begin
                    state <= IDLE;
                    resp_err <= resp_err | axi_bresp[1];
                end
                AR: if (axi_arready) begin
                    state <= R;
                    cnt <= '0;
                end
                R: if (axi_rvalid) begin
                    cnt <= cnt + 1'b1;
                    resp_err <= resp_err | axi_rresp[1] | (axi_rlast != last);
                    if (axi_rlast) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/iob_cache_be_axi_wb.md
Name: iob_cache_be_axi_wb

Overview:
- AXI4 back-end for the next-generation cache with write-back support.
- Performs full-line burst refills (read channel) and full-line dirty-line evictions (write burst), replacing the single-word write-through path.
- Sits between cache_memory (write-back variant) and the external AXI slave.
- Generalised for any BE_DATA_W that is a multiple of FE_DATA_W and any line length; reports bus errors.

Parameters:
FE_ADDR_W, 32, front-end byte-address width
FE_DATA_W, 32, cache word width
BE_ADDR_W, FE_ADDR_W, AXI address width
BE_DATA_W, 32, AXI data width, FE_DATA_W*2^k
WORD_OFF_W, 3, log2 words per line
AXI_ID_W, 1, AXI ID width
AXI_ID, 0, constant ID driven on arid/awid
Derived (not overridable):
- BE_BYTE_W = log2(BE_DATA_W/8)
- LINE2BE_W = WORD_OFF_W - log2(BE_DATA_W/FE_DATA_W), must be >= 1
- BEATS = 2^LINE2BE_W
- LINE_W = FE_DATA_W * 2^WORD_OFF_W
- LA_W = FE_ADDR_W - BE_BYTE_W - LINE2BE_W

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
wb_valid  in  1  evict request; held until wb_ready
wb_addr  in  LA_W  line address of evicted line
wb_line  in  LINE_W  line data, word 0 in LSBs
wb_ready  out  1  one-cycle pulse: eviction write response received
replace_valid  in  1  refill request
replace_addr  in  LA_W  line address to refill
replace  out  1  refill in progress
read_valid  out  1  refill beat valid
read_addr  out  LINE2BE_W  beat index within line
read_rdata  out  BE_DATA_W  beat data
resp_err  out  1  sticky bus/protocol error flag
axi_arvalid/araddr/arlen/arsize/arburst/arid  out  1/BE_ADDR_W/8/3/2/AXI_ID_W  read address
axi_arlock/arcache/arprot/arqos  out  1/4/3/4  constants 0/4'b0011/0/0
axi_arready  in  1
axi_rvalid/rdata/rresp/rlast  in  1/BE_DATA_W/2/1;  axi_rready  out  1
axi_awvalid/awaddr/awlen/awsize/awburst/awid  out  same widths as ar*
axi_awlock/awcache/awprot/awqos  out  same constants as ar*
axi_awready  in  1
axi_wvalid/wdata/wstrb/wlast  out  1/BE_DATA_W/BE_DATA_W/8/1;  axi_wready  in  1
axi_bvalid/bresp  in  1/2;  axi_bready  out  1

Behaviour:
- FSM states: IDLE, AW, W, B, AR, R.
- Reset: state IDLE, beat counter 0, resp_err 0. All valid/ready outputs, wb_ready and replace are 0.
- IDLE:
  - wb_valid -> AW; latch wb_addr and wb_line.
  - else replace_valid -> AR; latch replace_addr.
  - Eviction has priority when both are asserted the same cycle, so memory is updated before the refill reads it.
- AW: awvalid=1, awaddr={wb_addr, (BE_BYTE_W+LINE2BE_W) zeros}, awlen=BEATS-1, awsize=BE_BYTE_W, awburst=2'b01 (INCR). Fields stay stable until awready; then -> W, counter=0.
- W:
  - wvalid=1, wdata=latched line slice [cnt*BE_DATA_W +: BE_DATA_W], wstrb all ones, wlast=(cnt==BEATS-1).
  - Counter advances only on wvalid&wready.
  - Final beat accepted -> B.
- B: bready=1. On bvalid: wb_ready=1 (combinational, that cycle only), resp_err set if bresp[1], -> IDLE.
- AR: arvalid=1; araddr, arlen, arsize, arburst formed as in AW from replace_addr. On arready -> R, counter=0.
- R:
  - rready=1; read_valid=rvalid, read_addr=cnt, read_rdata=rdata.
  - Counter increments per rvalid beat.
  - On rvalid&rlast -> IDLE.
  - resp_err set on: rresp[1]; rlast with cnt!=BEATS-1; cnt==BEATS-1 without rlast.
- replace=1 in AR and R; falls the cycle after the rlast beat.
- Latency: refill request to arvalid is 1 cycle; the next request is accepted in the cycle after returning to IDLE.
- Requests arriving outside IDLE wait; masters hold valid.
- Reset mid-burst: return to IDLE next cycle with all outputs low; the slave is reset by the same system reset.
- Counter width is LINE2BE_W+1; no wrap within a burst.

Test Plan:
1. Defaults (8 beats). replace_valid, replace_addr=0x1234 -> araddr=0x24680, arlen=7, arsize=2, arburst=1. Send 8 beats 0xA0..0xA7 -> read_addr 0..7 with matching data; replace drops after beat 7; resp_err=0.
2. wb_valid, wb_addr=0x10, wb_line words 0..7 = 0x100..0x107 -> awaddr=0x200, awlen=7. wdata 0x100..0x107 in order, wlast only on 0x107. bvalid -> single-cycle wb_ready.
3. wb_valid and replace_valid in the same cycle -> AW/W/B complete first; arvalid rises only after wb_ready.
4. awready delayed 3 cycles, wready toggling 1/0 -> awaddr stable while waiting; exactly 8 beats, none skipped or repeated.
5. bresp=2'b10 -> resp_err=1 and stays 1 through later clean transfers until reset. Refill with rlast on beat 6 -> resp_err=1, FSM returns to IDLE.
6. reset asserted at W beat 3 -> next cycle all valid outputs 0, state IDLE. BE_DATA_W=64: arlen=3, 4 beats.
